// File: rtl/debug_send.sv
// Streams N_WORDS 32-bit debug words byte by byte to a UART transmitter.
// Define DEBUG_SEND_CHECKSUM_EN to append an XOR checksum byte to each frame.
module debug_send #(
  parameter int N_WORDS = 8,
  parameter int SEL_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_start_send,
  input  logic [31:0]      i_word,
  input  logic             is_tx_done,
  output logic [SEL_W-1:0] o_word_sel,
  output logic [7:0]       o_tx_data,
  output logic             os_tx_start,
  output logic             os_done_send
);

  localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IW-1:0] LAST_W = IW'(N_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    TX       = 3'd2,
    WAIT_TX  = 3'd3,
`ifdef DEBUG_SEND_CHECKSUM_EN
    CHK_TX   = 3'd4,
    CHK_WAIT = 3'd5,
`endif
    DONE     = 3'd6
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   word_q;
  logic [1:0]      byte_q;
  logic [31:0]     shift_q;

`ifdef DEBUG_SEND_CHECKSUM_EN
  logic [7:0]      csum_q;
  logic [7:0]      csum_d;

  assign csum_d = csum_q ^ shift_q[7:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      byte_q  <= '0;
      shift_q <= '0;
`ifdef DEBUG_SEND_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (is_start_send) begin
            word_q  <= '0;
            byte_q  <= '0;
`ifdef DEBUG_SEND_CHECKSUM_EN
            csum_q  <= '0;
`endif
            state_q <= LOAD;
          end
        end
        LOAD: begin
          shift_q <= i_word;
          state_q <= TX;
        end
        TX: state_q <= WAIT_TX;
        WAIT_TX: begin
          if (is_tx_done) begin
`ifdef DEBUG_SEND_CHECKSUM_EN
            csum_q <= csum_d;
`endif
            if (byte_q != 2'd3) begin
              shift_q <= {8'h00, shift_q[31:8]};
              byte_q  <= byte_q + 2'd1;
              state_q <= TX;
            end else if (word_q != LAST_W) begin
              word_q  <= word_q + IW'(1);
              byte_q  <= '0;
              state_q <= LOAD;
            end else begin
`ifdef DEBUG_SEND_CHECKSUM_EN
              // checksum byte rides the same shift path to o_tx_data
              shift_q <= {24'h0, csum_d};
              state_q <= CHK_TX;
`else
              state_q <= DONE;
`endif
            end
          end
        end
`ifdef DEBUG_SEND_CHECKSUM_EN
        CHK_TX: state_q <= CHK_WAIT;
        CHK_WAIT: begin
          if (is_tx_done) begin
            state_q <= DONE;
          end
        end
`endif
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_word_sel = SEL_W'(word_q);
  assign o_tx_data  = shift_q[7:0];

`ifdef DEBUG_SEND_CHECKSUM_EN
  assign os_tx_start = (state_q == TX) || (state_q == CHK_TX);
`else
  assign os_tx_start = (state_q == TX);
`endif
  assign os_done_send = (state_q == DONE);

endmodule

// File: tb/tb_debug_send.sv
// Scoreboard bench for debug_send: two instances (2-word and 1-word frames).
// Works with or without DEBUG_SEND_CHECKSUM_EN defined.
module tb_debug_send;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // instance A: two words
  logic        start_a, done_inj, tx_done_m_a, is_tx_done_a;
  logic [31:0] i_word_a;
  logic [7:0]  sel_a, data_a;
  logic        txs_a, done_a_o;

  assign is_tx_done_a = tx_done_m_a | done_inj;
  assign i_word_a = (sel_a == 8'd0) ? 32'h11223344 :
                    (sel_a == 8'd1) ? 32'hAABBCCDD : 32'hDEADBEEF;

  debug_send #(.N_WORDS(2), .SEL_W(8)) u_a (
    .clk(clk), .rst(rst), .is_start_send(start_a), .i_word(i_word_a),
    .is_tx_done(is_tx_done_a), .o_word_sel(sel_a), .o_tx_data(data_a),
    .os_tx_start(txs_a), .os_done_send(done_a_o)
  );

  // instance B: one word, slow transmitter
  logic        start_b, tx_done_m_b;
  logic [31:0] i_word_b;
  logic [7:0]  sel_b, data_b;
  logic        txs_b, done_b_o;

  assign i_word_b = (sel_b == 8'd0) ? 32'h000000FF : 32'hDEADBEEF;

  debug_send #(.N_WORDS(1), .SEL_W(8)) u_b (
    .clk(clk), .rst(rst), .is_start_send(start_b), .i_word(i_word_b),
    .is_tx_done(tx_done_m_b), .o_word_sel(sel_b), .o_tx_data(data_b),
    .os_tx_start(txs_b), .os_done_send(done_b_o)
  );

  // expected {word_sel, byte}
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  int done_a = 0, done_b = 0, starts_a = 0, starts_b = 0;
  int dly_a = 10, dly_b = 1000;

  logic [15:0] exp_a [8] = '{16'h0044, 16'h0033, 16'h0022, 16'h0011,
                             16'h01DD, 16'h01CC, 16'h01BB, 16'h01AA};
  logic [15:0] exp_b [4] = '{16'h00FF, 16'h0000, 16'h0000, 16'h0000};

  task automatic push_a();
    foreach (exp_a[i]) q_a.push_back(exp_a[i]);
`ifdef DEBUG_SEND_CHECKSUM_EN
    q_a.push_back(16'h0144);
`endif
  endtask

  task automatic push_b();
    foreach (exp_b[i]) q_b.push_back(exp_b[i]);
`ifdef DEBUG_SEND_CHECKSUM_EN
    q_b.push_back(16'h00FF);
`endif
  endtask

  // monitors
  always @(negedge clk) begin
    logic [15:0] e;
    if (txs_a) begin
      starts_a++;
      if (q_a.size() == 0) chk("a_extra_byte", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        chk("a_byte", {24'h0, data_a}, {24'h0, e[7:0]});
        chk("a_sel", {24'h0, sel_a}, {24'h0, e[15:8]});
      end
    end
    if (done_a_o) begin
      done_a++;
      chk("a_bytes_left_at_done", q_a.size(), 32'd0);
    end
    if (txs_b) begin
      starts_b++;
      if (q_b.size() == 0) chk("b_extra_byte", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        chk("b_byte", {24'h0, data_b}, {24'h0, e[7:0]});
        chk("b_sel", {24'h0, sel_b}, {24'h0, e[15:8]});
      end
    end
    if (done_b_o) begin
      done_b++;
      chk("b_bytes_left_at_done", q_b.size(), 32'd0);
    end
  end

  // UART transmitter models
  initial begin
    logic [7:0] cap;
    logic stable, ok;
    tx_done_m_a = 1'b0;
    forever begin
      @(negedge clk);
      tx_done_m_a = 1'b0;
      if (txs_a && rst) begin
        cap = data_a; stable = 1'b1; ok = 1'b1;
        for (int i = 0; i < dly_a; i++) begin
          @(negedge clk);
          if (!rst) ok = 1'b0;
          if (data_a !== cap) stable = 1'b0;
        end
        if (ok) begin
          chk("a_tx_data_stable", {31'h0, stable}, 32'd1);
          tx_done_m_a = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [7:0] cap;
    logic stable, ok;
    tx_done_m_b = 1'b0;
    forever begin
      @(negedge clk);
      tx_done_m_b = 1'b0;
      if (txs_b && rst) begin
        cap = data_b; stable = 1'b1; ok = 1'b1;
        for (int i = 0; i < dly_b; i++) begin
          @(negedge clk);
          if (!rst) ok = 1'b0;
          if (data_b !== cap) stable = 1'b0;
        end
        if (ok) begin
          chk("b_tx_data_stable", {31'h0, stable}, 32'd1);
          tx_done_m_b = 1'b1;
        end
      end
    end
  end

  task automatic wait_done_a(input int target);
    for (int i = 0; i < 2000 && done_a < target; i++) @(negedge clk);
    chk("a_done_count", done_a, target);
    repeat (20) @(negedge clk);
    chk("a_single_done", done_a, target);
  endtask

  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  initial begin
    int base;
    start_a = 1'b0; start_b = 1'b0; done_inj = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_a_data", {24'h0, data_a}, 32'h0);
    chk("rst_a_start", {31'h0, txs_a}, 32'h0);
    chk("rst_a_done", {31'h0, done_a_o}, 32'h0);
    chk("rst_a_sel", {24'h0, sel_a}, 32'h0);
    chk("rst_b_data", {24'h0, data_b}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // frame 1: nominal, with start latency check
    push_a();
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    chk("lat_k_no_start", {31'h0, txs_a}, 32'h0);
    @(posedge clk);
    #1;
    chk("lat_k2_start", {31'h0, txs_a}, 32'h1);
    chk("lat_k2_sel", {24'h0, sel_a}, 32'h0);
    wait_done_a(1);

    // frame 2: stray tx_done in IDLE and TX, second start mid-frame
    @(negedge clk);
    done_inj = 1'b1;
    @(negedge clk);
    done_inj = 1'b0;
    push_a();
    pulse_start_a();
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        if (txs_a) seen = 1'b1;
        else @(negedge clk);
      end
      chk("f2_first_start_seen", {31'h0, seen}, 32'h1);
    end
    done_inj = 1'b1;
    @(negedge clk);
    done_inj = 1'b0;
    repeat (30) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(2);

    // frame 3: reset during byte 5, then a clean restart
    push_a();
    base = starts_a;
    pulse_start_a();
    for (int i = 0; i < 500 && starts_a < base + 5; i++) @(negedge clk);
    chk("f3_reached_byte5", starts_a - base, 32'd5);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_data", {24'h0, data_a}, 32'h0);
    chk("mid_rst_start", {31'h0, txs_a}, 32'h0);
    chk("mid_rst_done", {31'h0, done_a_o}, 32'h0);
    chk("mid_rst_sel", {24'h0, sel_a}, 32'h0);
    q_a.delete();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    chk("no_done_after_rst", done_a, 32'd2);
    push_a();
    pulse_start_a();
    wait_done_a(3);

    // one-word frame with a slow transmitter
    push_b();
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (500) @(negedge clk);
    chk("b_holds_in_wait", starts_b, 32'd1);
    chk("b_no_early_done", done_b, 32'd0);
    for (int i = 0; i < 6000 && done_b < 1; i++) @(negedge clk);
    chk("b_done_count", done_b, 32'd1);
    chk("b_bytes_left", q_b.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
